// File: rtl/sm_clk_ctrl.sv
// Run/step/halt sequencer producing a qualified CPU clock-enable at a power-of-two period.
// Define SM_CLK_CTRL_TICKCNT_EN to build the 32-bit tickCnt pulse counter; otherwise tickCnt reads 0.
module sm_clk_ctrl #(
    parameter int SHIFT = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [1:0]       cmdOp,
    input  logic [3:0]       cmdDevide,
    input  logic [CNT_W-1:0] cmdCount,
    input  logic             halt,
    output logic             cpuEn,
    output logic             running,
    output logic             done,
    output logic [31:0]      tickCnt
);

    localparam int PW = SHIFT + 16;
    localparam logic [PW-1:0] PRE_ONES = {PW{1'b1}};

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       dev_q, dev_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             done_q, done_d;
    logic [PW-1:0]    period_m1;
    logic             tick;
    logic             accept;

    // P-1 is SHIFT+devR low ones; shifting the all-ones word keeps it within PW bits.
    assign period_m1 = PRE_ONES >> (5'd16 - {1'b0, dev_q});
    assign tick      = (pre_q == period_m1);
    assign running   = (state_q != S_HALT);
    assign cpuEn     = running & tick & ~halt;
    assign cmdReady  = ~halt & (state_q != S_BURST);
    assign accept    = cmdValid & cmdReady;
    assign done      = done_q;

    always_comb begin
        state_d  = state_q;
        dev_d    = dev_q;
        pre_d    = pre_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        if (halt) begin
            state_d = S_HALT;
            pre_d   = '0;
        end else if (accept) begin
            dev_d = cmdDevide;
            pre_d = '0;
            case (cmdOp)
                2'd0: state_d = S_HALT;
                2'd1: state_d = S_RUN;
                2'd2: begin
                    remain_d = CNT_W'(1);
                    state_d  = S_BURST;
                end
                default: begin
                    // An empty burst completes immediately without ever leaving halt.
                    if (cmdCount == '0) begin
                        state_d = S_HALT;
                        done_d  = 1'b1;
                    end else begin
                        remain_d = cmdCount;
                        state_d  = S_BURST;
                    end
                end
            endcase
        end else begin
            case (state_q)
                S_RUN: pre_d = tick ? '0 : pre_q + 1'b1;
                S_BURST: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (cpuEn) begin
                        remain_d = remain_q - CNT_W'(1);
                        if (remain_q == CNT_W'(1)) begin
                            state_d = S_HALT;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: pre_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_HALT;
            dev_q    <= '0;
            pre_q    <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dev_q    <= dev_d;
            pre_q    <= pre_d;
            remain_q <= remain_d;
            done_q   <= done_d;
        end
    end

`ifdef SM_CLK_CTRL_TICKCNT_EN
    logic [31:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (cpuEn) tick_cnt_d = tick_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt_q <= '0;
        else     tick_cnt_q <= tick_cnt_d;
    end

    assign tickCnt = tick_cnt_q;
`else
    assign tickCnt = 32'h0;
`endif

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Randomized self-checking bench for sm_clk_ctrl with SHIFT=0, compared cycle by cycle
// against a model based on cycles-since-accept arithmetic.
module tb_sm_clk_ctrl;

    localparam int SHIFT = 0;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [3:0]       cmd_devide = 4'd0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             halt = 1'b0;
    logic             cpu_en;
    logic             running;
    logic             done;
    logic [31:0]      tick_cnt;

    int checks = 0;
    int failures = 0;

    // Model: mode 0=halted, 1=free run, 2=counted burst; age = cycles since the last accept.
    int          m_mode;
    int          m_age;
    int          m_period;
    int          m_remain;
    bit          m_done;
    logic [31:0] m_ticks;

    sm_clk_ctrl #(.SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmdValid  (cmd_valid),
        .cmdReady  (cmd_ready),
        .cmdOp     (cmd_op),
        .cmdDevide (cmd_devide),
        .cmdCount  (cmd_count),
        .halt      (halt),
        .cpuEn     (cpu_en),
        .running   (running),
        .done      (done),
        .tickCnt   (tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [31:0] expTicks();
`ifdef SM_CLK_CTRL_TICKCNT_EN
        return m_ticks;
`else
        return 32'h0;
`endif
    endfunction

    task automatic modelReset();
        m_mode   = 0;
        m_age    = 0;
        m_period = 1;
        m_remain = 0;
        m_done   = 1'b0;
        m_ticks  = '0;
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, then advance the model.
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [3:0] dev,
                                 input logic [CNT_W-1:0] cnt, input logic h);
        bit exp_run, exp_en, exp_ready, acc, new_done;
        cmd_valid  = v;
        cmd_op     = op;
        cmd_devide = dev;
        cmd_count  = cnt;
        halt       = h;
        @(negedge clk);
        exp_run   = (m_mode != 0);
        exp_en    = exp_run && (m_age % m_period == 0) && !h;
        exp_ready = !h && (m_mode != 2);
        checkOutput("cpuEn", {31'b0, cpu_en}, {31'b0, exp_en});
        checkOutput("running", {31'b0, running}, {31'b0, exp_run});
        checkOutput("cmdReady", {31'b0, cmd_ready}, {31'b0, exp_ready});
        checkOutput("done", {31'b0, done}, {31'b0, m_done});
        checkOutput("tickCnt", tick_cnt, expTicks());
        acc      = v && exp_ready;
        new_done = 1'b0;
        if (exp_en) m_ticks = m_ticks + 32'd1;
        if (h) begin
            m_mode = 0;
        end else if (acc) begin
            m_period = 1 << (SHIFT + int'(dev));
            m_age    = 0;
            case (op)
                2'd0: m_mode = 0;
                2'd1: m_mode = 1;
                2'd2: begin m_mode = 2; m_remain = 1; end
                default: begin
                    if (cnt == 0) begin m_mode = 0; new_done = 1'b1; end
                    else begin m_mode = 2; m_remain = int'(cnt); end
                end
            endcase
        end else if (m_mode == 2 && exp_en) begin
            m_remain--;
            if (m_remain == 0) begin m_mode = 0; new_done = 1'b1; end
        end
        m_age++;
        m_done = new_done;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 4'd0, '0, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cpuEn"}, {31'b0, cpu_en}, 32'd0);
        checkOutput({tag, "_running"}, {31'b0, running}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_cmdReady"}, {31'b0, cmd_ready}, 32'd1);
        checkOutput({tag, "_tickCnt"}, tick_cnt, 32'd0);
    endtask

    initial begin
        modelReset();
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        idle(3);
        // RUN devide=2: pulses at 4, 8, 12 cycles after accept.
        applyStimulus(1'b1, 2'd1, 4'd2, '0, 1'b0);
        idle(12);
        applyStimulus(1'b1, 2'd1, 4'd0, '0, 1'b0);
        idle(5);
        applyStimulus(1'b1, 2'd0, 4'd0, '0, 1'b0);
        idle(2);
        // BURST of 3, two cycles apart.
        applyStimulus(1'b1, 2'd3, 4'd1, 16'd3, 1'b0);
        idle(9);
        // STEP, then empty BURST.
        applyStimulus(1'b1, 2'd2, 4'd0, '0, 1'b0);
        idle(3);
        applyStimulus(1'b1, 2'd3, 4'd2, 16'd0, 1'b0);
        idle(3);
        // BURST of 5 with halt and a concurrent RUN on the 2nd pulse.
        applyStimulus(1'b1, 2'd3, 4'd1, 16'd5, 1'b0);
        idle(3);
        applyStimulus(1'b1, 2'd1, 4'd0, '0, 1'b1);
        idle(6);
        // Asynchronous reset in the middle of RUN.
        applyStimulus(1'b1, 2'd1, 4'd1, '0, 1'b0);
        idle(7);
        rst = 1'b1;
        #2;
        checkResetOutputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 4)),
                          ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
